// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if -- register-side bundle of the 16-channel PWM peripheral.
//   en_reg_out_7_0 / en_reg_out_15_8 : per-channel output enable
//   en_reg_pwm_7_0 / en_reg_pwm_15_8 : per-channel PWM mode select
//   pwm_duty_cycle                   : requested duty, 0 = low .. 255 = high
//   out                              : registered channel outputs
//   period_start                     : one-cycle pulse at each period boundary
// slave modport is the peripheral side, master modport the driver side.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out,
    output period_start
  );

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out,
    input  period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral -- 16-channel PWM generator with one shared prescaler,
// 8-bit period counter and comparator.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : pwm_peripheral_if.slave (enables, duty in; out, period_start out)
// PRESCALE clk cycles form one counter step; a period is 256 steps. The duty
// value is shadowed at the period boundary so mid-period writes only take
// effect from the next period. Enables act on the very next clk edge.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic               clk,
  input  logic               rst,
  pwm_peripheral_if.slave    bus
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_sh;

  logic        tick_p0;
  logic        wrap_p0;
  logic        pwm_level_p0;
  logic [15:0] en_out_p0;
  logic [15:0] en_pwm_p0;

  logic [15:0] out_p1;
  logic        period_start_p1;

  // 255 is special-cased so the channel never drops for the last step.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == 8'hFF) || (cnt < duty);
  endfunction

  // Stage p0: counter state and enables decoded combinationally.
  always_comb begin
    tick_p0      = (pre_cnt == PRE_LAST);
    wrap_p0      = tick_p0 && (pwm_cnt == 8'hFF);
    pwm_level_p0 = pwm_level(pwm_cnt, duty_sh);
    en_out_p0    = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm_p0    = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  end

  // Stage p1: registered counters, shadow duty and channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt         <= 16'h0000;
      pwm_cnt         <= 8'h00;
      duty_sh         <= 8'h00;
      out_p1          <= 16'h0000;
      period_start_p1 <= 1'b0;
    end else begin
      if (tick_p0) begin
        pre_cnt <= 16'h0000;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 16'd1;
      end
      if (wrap_p0) begin
        duty_sh <= bus.pwm_duty_cycle;
      end
      out_p1          <= en_out_p0 & (~en_pwm_p0 | {16{pwm_level_p0}});
      period_start_p1 <= wrap_p0;
    end
  end

  assign bus.out          = out_p1;
  assign bus.period_start = period_start_p1;

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter: PRESCALE, default 13, clk cycles per PWM counter step; legal range 1..65535.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en_reg_out_7_0  input  8  output enable, channels 7..0 (bit i = channel i).
REQ-005 Port: en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-006 Port: en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
REQ-007 Port: en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
REQ-008 Port: pwm_duty_cycle  input  8  requested duty, 0 = always low, 255 = always high.
REQ-009 Port: out  output  16  channel outputs, registered.
REQ-010 Port: period_start  output  1  one-cycle pulse at start of each PWM period.
REQ-011 Clock is clk only; reset rst is asynchronous and active-high; both polarity and synchronicity are fixed.
REQ-012 All inputs are already synchronous to clk; no input synchronisers in this block.

Function
REQ-013 Prescaler pre_cnt (16 bit) counts 0..PRESCALE-1, wraps to 0; tick = (pre_cnt == PRESCALE-1); PRESCALE=1 -> tick every cycle.
REQ-014 Period counter pwm_cnt (8 bit) increments by 1 on tick, wraps 255 -> 0; period = 256*PRESCALE clk cycles.
REQ-015 Shadow duty duty_sh loads pwm_duty_cycle only on tick with pwm_cnt==255 (same edge pwm_cnt becomes 0); otherwise holds.
REQ-016 Duty changes mid-period SHALL NOT affect the current period; effect starts at next period boundary.
REQ-017 pwm_level = 1 if duty_sh==255; else 1 iff pwm_cnt < duty_sh (unsigned 8-bit compare).
REQ-018 Resulting high time per period: duty_sh*PRESCALE cycles for 0..254; full period for 255.
REQ-019 Per channel i, next out[i] = en_out[i] AND (NOT en_pwm[i] OR pwm_level), registered; 1 clk latency from enables and pwm_cnt.
REQ-020 en_out[i]=0 -> out[i]=0 regardless of en_pwm[i]; en_out=1,en_pwm=0 -> static high.
REQ-021 Enable changes apply on next clk edge, not deferred to period boundary.
REQ-022 period_start registered, high for exactly one cycle on the edge where pwm_cnt wraps 255 -> 0 (same edge duty_sh loads).
REQ-023 period_start SHALL NOT assert at reset release; first pulse after first full 256-step period.
REQ-024 All channels share one counter/comparator; outputs of PWM channels with same mode are cycle-aligned.

Reset
REQ-025 rst=1 asynchronously forces pre_cnt=0, pwm_cnt=0, duty_sh=0, out=16'h0000, period_start=0.
REQ-026 Reset asserted mid-period aborts the period; after release counting restarts from pre_cnt=0, pwm_cnt=0.
REQ-027 duty_sh=0 after reset: PWM channels stay low for first period even if pwm_duty_cycle!=0.
REQ-028 First clk edge after rst deasserts performs normal update (out reflects enables one cycle later).

Verification
REQ-029 PRESCALE=1, en_out=en_pwm=16'hFFFF, duty=128 held -> from 2nd period on, out=16'hFFFF for 128 cycles then 16'h0000 for 128, repeating every 256.
REQ-030 duty=0 and duty=255 (PRESCALE=1, all PWM) -> out constantly 16'h0000, resp. constantly 16'hFFFF after first boundary; no single-cycle glitches.
REQ-031 en_out=16'h00F0, en_pwm=16'h0030, duty=64 -> out[7:6] static 1, out[5:4] PWM 25%, all other bits 0.
REQ-032 duty changed 64 -> 192 at pwm_cnt=100 -> current period keeps 64-step high time; next period high 192 steps; period_start pulse every 256*PRESCALE cycles.
REQ-033 PRESCALE=13, duty=1 -> high exactly 13 cycles per 3328-cycle period; pre_cnt wrap verified.
REQ-034 rst pulsed asynchronously at pwm_cnt=200 -> out=0 and period_start=0 immediately; counting restarts at 0; PWM channels low for first 256 steps.
